// File: rtl/uart_tx_en.sv
// 8N1 UART transmitter with a one-byte holding register, bit timing from an external
// oversample tick. Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_en #(
   parameter int unsigned Oversample = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       out,
   output logic       busy,
   output logic       done
);

   localparam int unsigned     CntW    = (Oversample > 1) ? $clog2(Oversample) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(Oversample - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] StParity = 3'd4;
`endif

   logic [2:0]      state, state_d;
   logic [CntW-1:0] sample_count, count_d;
   logic [2:0]      bit_count, bit_d;
   logic [7:0]      shift_reg, shift_d;
   logic [7:0]      buf_data;
   logic            buf_full;
   logic            load, bit_end, frame_end, out_d;
`ifdef UART_TX_PARITY_EN
   logic            parity, parity_d;
`endif

   always_comb begin
      state_d   = state;
      count_d   = sample_count;
      bit_d     = bit_count;
      shift_d   = shift_reg;
      load      = 1'b0;
      frame_end = 1'b0;
      bit_end   = (sample_count == '0);
      if (en) begin
         count_d = sample_count - CntW'(1);
         case (state)
            StIdle: begin
               count_d = CntLoad;
               if (buf_full) begin
                  load    = 1'b1;
                  state_d = StStart;
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_d = StData;
                  bit_d   = 3'd7;
                  count_d = CntLoad;
               end
            end
            StData: begin
               if (bit_end) begin
                  shift_d = {1'b0, shift_reg[7:1]};
                  bit_d   = bit_count - 3'd1;
                  count_d = CntLoad;
                  if (bit_count == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  state_d = StStop;
                  count_d = CntLoad;
               end
            end
`endif
            StStop: begin
               if (bit_end) begin
                  frame_end = 1'b1;
                  count_d   = CntLoad;
                  // A buffered byte starts its start bit immediately, with no idle gap.
                  if (buf_full) begin
                     load    = 1'b1;
                     state_d = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: begin
               state_d = StIdle;
               count_d = CntLoad;
            end
         endcase
      end
      if (load) begin
         shift_d = buf_data;
      end
`ifdef UART_TX_PARITY_EN
      parity_d = load ? ^buf_data : parity;
`endif
      // The line register follows the state being entered, so it changes with the state.
      case (state_d)
         StStart:  out_d = 1'b0;
         StData:   out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: out_d = parity_d;
`endif
         default:  out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= StIdle;
         sample_count <= CntLoad;
         bit_count    <= 3'd0;
         shift_reg    <= 8'd0;
         buf_data     <= 8'd0;
         buf_full     <= 1'b0;
         out          <= 1'b1;
         done         <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity       <= 1'b0;
`endif
      end else begin
         state        <= state_d;
         sample_count <= count_d;
         bit_count    <= bit_d;
         shift_reg    <= shift_d;
         out          <= out_d;
         done         <= frame_end;
`ifdef UART_TX_PARITY_EN
         parity       <= parity_d;
`endif
         if (load) begin
            buf_full <= 1'b0;
         end else if (valid && !buf_full) begin
            buf_full <= 1'b1;
            buf_data <= data;
         end
      end
   end

   assign ready = !buf_full;
   assign busy  = (state != StIdle) || buf_full;

endmodule
